// File: rtl/sd_init_ctrl_if.sv
// sd_init_ctrl_if
// Command bus between the SD init sequencer and the sd_cmd command engine.
//   cmd_number : command byte, 0x40 | index       (master -> slave)
//   cmd_args   : 32-bit command argument           (master -> slave)
//   cmd_crc    : CRC7 byte including the end bit   (master -> slave)
//   cmd_start  : held high until cmd_done is seen  (master -> slave)
//   cmd_done   : command finished, response valid  (slave -> master)
//   cmd_resp   : R1 response flags                 (slave -> master)
//   cmd_data   : data word returned by a read      (slave -> master)
interface sd_init_ctrl_if;
  logic [7:0]  cmd_number;
  logic [31:0] cmd_args;
  logic [7:0]  cmd_crc;
  logic        cmd_start;
  logic        cmd_done;
  logic [7:0]  cmd_resp;
  logic [31:0] cmd_data;

  modport master (
    output cmd_number, cmd_args, cmd_crc, cmd_start,
    input  cmd_done, cmd_resp, cmd_data
  );

  modport slave (
    input  cmd_number, cmd_args, cmd_crc, cmd_start,
    output cmd_done, cmd_resp, cmd_data
  );
endinterface

// File: rtl/sd_init_ctrl.sv
// sd_init_ctrl
// Brings an SPI-mode SD card from power-up to ready (power-up clocks, CMD0,
// CMD8, CMD55/ACMD41 loop) and then serves single-block CMD17 reads.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   init_start   : start/restart initialization (IDLE, READY, ERROR only)
//   read_req     : request one CMD17 read at read_addr (READY only)
//   ready, busy  : status; busy is high outside IDLE/READY/ERROR
//   error        : sticky failure flag, err_code gives the failing step
//   read_data    : last word read, read_valid pulses when it updates
//   cs_n         : card chip select
//   sd           : command bus to sd_cmd (master side)
// All outputs are registered; they are decoded from the next state.
module sd_init_ctrl #(
  parameter int POWERUP_CYCLES = 80,
  parameter int RETRY_MAX      = 255,
  parameter int GAP_CYCLES     = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init_start,
  input  logic          read_req,
  input  logic [31:0]   read_addr,
  output logic          ready,
  output logic          busy,
  output logic          error,
  output logic [2:0]    err_code,
  output logic [31:0]   read_data,
  output logic          read_valid,
  output logic          cs_n,
  sd_init_ctrl_if.master sd
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_POWERUP, ST_CMD0, ST_CMD8, ST_CMD55,
    ST_ACMD41, ST_CMD17, ST_GAP, ST_READY, ST_ERROR
  } state_t;

  localparam logic [2:0]  ERR_CMD0   = 3'd1;
  localparam logic [2:0]  ERR_CMD8   = 3'd2;
  localparam logic [2:0]  ERR_CMD55  = 3'd3;
  localparam logic [2:0]  ERR_ACMD41 = 3'd4;
  localparam logic [2:0]  ERR_CMD17  = 3'd5;

  // One dwell counter serves POWERUP, GAP and the CMD17 timeout: it restarts
  // at 0 on every state change, so in a SEND state it is the cycle index
  // since cmd_start rose.
  localparam logic [10:0] PU_LAST     = 11'(POWERUP_CYCLES - 1);
  localparam logic [10:0] GAP_LAST    = 11'(GAP_CYCLES - 1);
  localparam logic [10:0] CMD17_LIMIT = 11'd1000;
  localparam logic [10:0] CYC_MAX     = 11'h7FF;
  localparam logic [8:0]  RETRY_LIM   = 9'(RETRY_MAX);

  state_t      state, state_next;
  state_t      gap_ret, gap_ret_next;   // command to issue after the gap
  logic [10:0] cyc_cnt;
  logic [7:0]  retry_cnt;
  logic [8:0]  retry_after;
  logic [2:0]  fail_code;

  logic        ready_d, busy_d, error_d, read_valid_d, cs_n_d, start_d;
  logic [2:0]  err_code_d;
  logic [31:0] read_data_d, args_d;
  logic [7:0]  number_d, crc_d;

  assign retry_after = {1'b0, retry_cnt} + 9'd1;

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_next   = state;
    gap_ret_next = gap_ret;
    fail_code    = 3'd0;
    case (state)
      ST_IDLE:    if (init_start) state_next = ST_POWERUP;
      ST_POWERUP: if (cyc_cnt == PU_LAST) state_next = ST_CMD0;
      ST_CMD0: if (sd.cmd_done) begin
        if (sd.cmd_resp == 8'h01) begin
          state_next = ST_GAP; gap_ret_next = ST_CMD8;
        end else begin
          state_next = ST_ERROR; fail_code = ERR_CMD0;
        end
      end
      ST_CMD8: if (sd.cmd_done) begin
        if (sd.cmd_resp == 8'h01) begin
          state_next = ST_GAP; gap_ret_next = ST_CMD55;
        end else begin
          state_next = ST_ERROR; fail_code = ERR_CMD8;
        end
      end
      ST_CMD55: if (sd.cmd_done) begin
        if (sd.cmd_resp == 8'h00 || sd.cmd_resp == 8'h01) begin
          state_next = ST_GAP; gap_ret_next = ST_ACMD41;
        end else begin
          state_next = ST_ERROR; fail_code = ERR_CMD55;
        end
      end
      ST_ACMD41: if (sd.cmd_done) begin
        if (sd.cmd_resp == 8'h00) begin
          state_next = ST_READY;
        end else if (sd.cmd_resp == 8'h01 && retry_after < RETRY_LIM) begin
          state_next = ST_GAP; gap_ret_next = ST_CMD55;
        end else begin
          state_next = ST_ERROR; fail_code = ERR_ACMD41;
        end
      end
      ST_CMD17: if (sd.cmd_done) begin
        if (sd.cmd_resp == 8'h00 && cyc_cnt <= CMD17_LIMIT) begin
          state_next = ST_READY;
        end else begin
          state_next = ST_ERROR; fail_code = ERR_CMD17;
        end
      end
      ST_GAP: if (cyc_cnt == GAP_LAST) state_next = gap_ret;
      ST_READY: begin
        if (init_start)    state_next = ST_POWERUP;
        else if (read_req) state_next = ST_CMD17;
      end
      ST_ERROR:   if (init_start) state_next = ST_POWERUP;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output decode from the next state, registered below
  always_comb begin
    ready_d      = (state_next == ST_READY);
    busy_d       = !(state_next inside {ST_IDLE, ST_READY, ST_ERROR});
    error_d      = (state_next == ST_ERROR);
    cs_n_d       = (state_next inside {ST_IDLE, ST_POWERUP, ST_ERROR});
    read_valid_d = (state == ST_CMD17) && (state_next == ST_READY);
    read_data_d  = read_valid_d ? sd.cmd_data : read_data;
    if (state_next != ST_ERROR) err_code_d = 3'd0;
    else if (state == ST_ERROR) err_code_d = err_code;
    else                        err_code_d = fail_code;
    start_d  = 1'b0;
    number_d = 8'h00;
    args_d   = 32'h0;
    crc_d    = 8'h00;
    case (state_next)
      ST_CMD0:   begin start_d = 1'b1; number_d = 8'h40; crc_d = 8'h95; end
      ST_CMD8:   begin start_d = 1'b1; number_d = 8'h48; args_d = 32'h0000_01AA; crc_d = 8'h87; end
      ST_CMD55:  begin start_d = 1'b1; number_d = 8'h77; crc_d = 8'h65; end
      ST_ACMD41: begin start_d = 1'b1; number_d = 8'h69; args_d = 32'h4000_0000; crc_d = 8'h77; end
      ST_CMD17: begin
        start_d  = 1'b1;
        number_d = 8'h51;
        // read_addr is only sampled on entry; hold it while the read runs
        args_d   = (state == ST_CMD17) ? sd.cmd_args : read_addr;
        crc_d    = 8'hFF;
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      gap_ret       <= ST_IDLE;
      cyc_cnt       <= 11'd0;
      retry_cnt     <= 8'd0;
      ready         <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
      err_code      <= 3'd0;
      read_data     <= 32'h0;
      read_valid    <= 1'b0;
      cs_n          <= 1'b1;
      sd.cmd_start  <= 1'b0;
      sd.cmd_number <= 8'h00;
      sd.cmd_args   <= 32'h0;
      sd.cmd_crc    <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_next;
      gap_ret <= gap_ret_next;
      if (state_next != state)  cyc_cnt <= 11'd0;
      else if (cyc_cnt != CYC_MAX) cyc_cnt <= cyc_cnt + 11'd1;
      if (state_next == ST_CMD0 && state != ST_CMD0)
        retry_cnt <= 8'd0;
      else if (state == ST_ACMD41 && sd.cmd_done && sd.cmd_resp == 8'h01)
        retry_cnt <= retry_cnt + 8'd1;
      ready         <= ready_d;
      busy          <= busy_d;
      error         <= error_d;
      err_code      <= err_code_d;
      read_data     <= read_data_d;
      read_valid    <= read_valid_d;
      cs_n          <= cs_n_d;
      sd.cmd_start  <= start_d;
      sd.cmd_number <= number_d;
      sd.cmd_args   <= args_d;
      sd.cmd_crc    <= crc_d;
    end
  end

endmodule

// File: tb/tb_sd_init_ctrl.sv
// tb_sd_init_ctrl
// Randomized bench for sd_init_ctrl. A card/sd_cmd responder answers each
// command after a random latency; a reference model derives the expected
// command list, final status and read results from the card's answers.
module tb_sd_init_ctrl;
  localparam int POWERUP_CYCLES = 80;
  localparam int RETRY_MAX      = 3;
  localparam int GAP_CYCLES     = 2;

  logic        clk = 1'b0;
  logic        reset, init_start, read_req;
  logic [31:0] read_addr;
  logic        ready, busy, error, read_valid, cs_n;
  logic [2:0]  err_code;
  logic [31:0] read_data;

  sd_init_ctrl_if bus();

  sd_init_ctrl #(
    .POWERUP_CYCLES(POWERUP_CYCLES),
    .RETRY_MAX     (RETRY_MAX),
    .GAP_CYCLES    (GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init_start(init_start),
    .read_req  (read_req),
    .read_addr (read_addr),
    .ready     (ready),
    .busy      (busy),
    .error     (error),
    .err_code  (err_code),
    .read_data (read_data),
    .read_valid(read_valid),
    .cs_n      (cs_n),
    .sd        (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  num;
    logic [31:0] args;
    logic [7:0]  crc;
  } cmd_t;

  cmd_t obs_q[$];
  cmd_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [7:0] n, input logic [31:0] a, input logic [7:0] c);
    cmd_t t;
    t = {n, a, c};
    return t;
  endfunction

  // Card behaviour
  logic [7:0]  r_cmd0 = 8'h01, r_cmd8 = 8'h01, r_cmd55 = 8'h01, r_cmd17 = 8'h00;
  int          a41_busy = 0, a41_cnt = 0, lat8 = 0, lat17 = 1;
  logic [31:0] d17 = 32'h0;

  // Monitor state
  int          rv_cnt = 0, gap_run = 0, pu_run = 0, idx = 0, lat = 1;
  logic        rv_ready = 1'b0, in_cmd = 1'b0;
  logic [31:0] rv_data = 32'h0;
  logic [7:0]  cur = 8'h00;
  logic [31:0] exp_rd = 32'h0;

  // Responder and monitor: everything sampled on the falling edge
  initial begin
    cmd_t t;
    bus.cmd_done = 1'b0;
    bus.cmd_resp = 8'h00;
    bus.cmd_data = 32'h0;
    forever begin
      @(negedge clk);
      if (read_valid) begin
        rv_cnt++;
        rv_ready = ready;
        rv_data  = read_data;
      end
      if (bus.cmd_start && !in_cmd) begin
        in_cmd = 1'b1;
        idx    = 0;
        cur    = bus.cmd_number;
        t      = {bus.cmd_number, bus.cmd_args, bus.cmd_crc};
        obs_q.push_back(t);
        if (cur inside {8'h48, 8'h77, 8'h69}) check("gap_len", gap_run, GAP_CYCLES);
        if (cur == 8'h40) check("powerup_len", pu_run, POWERUP_CYCLES);
        if (cur == 8'h51)                  lat = lat17;
        else if (cur == 8'h48 && lat8 > 0) lat = lat8;
        else                               lat = $urandom_range(1, 6);
      end else if (bus.cmd_start) begin
        idx++;
      end
      gap_run = bus.cmd_start ? 0 : gap_run + 1;
      pu_run  = (busy && cs_n) ? pu_run + 1 : 0;
      if (bus.cmd_start && idx == lat) begin
        bus.cmd_done = 1'b1;
        bus.cmd_data = $urandom;
        case (cur)
          8'h40: bus.cmd_resp = r_cmd0;
          8'h48: bus.cmd_resp = r_cmd8;
          8'h77: bus.cmd_resp = r_cmd55;
          8'h69: begin
            bus.cmd_resp = (a41_busy < 0 || a41_cnt < a41_busy) ? 8'h01 : 8'h00;
            a41_cnt++;
          end
          8'h51: begin
            bus.cmd_resp = r_cmd17;
            bus.cmd_data = d17;
          end
          default: bus.cmd_resp = 8'hFF;
        endcase
      end else begin
        bus.cmd_done = 1'b0;
        bus.cmd_resp = 8'($urandom);
        bus.cmd_data = $urandom;
      end
      if (!bus.cmd_start) in_cmd = 1'b0;
    end
  end

  // Reference model of initialization: command list and outcome
  task automatic model_init(input logic [7:0] r0, input logic [7:0] r8, input logic [7:0] r55,
                            input int busy_n, output logic ok, output logic [2:0] code);
    exp_q.delete();
    ok   = 1'b0;
    code = 3'd0;
    exp_q.push_back(mk(8'h40, 32'h0, 8'h95));
    if (r0 != 8'h01) begin code = 3'd1; return; end
    exp_q.push_back(mk(8'h48, 32'h0000_01AA, 8'h87));
    if (r8 != 8'h01) begin code = 3'd2; return; end
    for (int attempt = 1; attempt <= 300; attempt++) begin
      exp_q.push_back(mk(8'h77, 32'h0, 8'h65));
      if (r55 > 8'h01) begin code = 3'd3; return; end
      exp_q.push_back(mk(8'h69, 32'h4000_0000, 8'h77));
      if (!(busy_n < 0 || attempt <= busy_n)) begin ok = 1'b1; return; end
      if (attempt >= RETRY_MAX) begin code = 3'd4; return; end
    end
  endtask

  task automatic compare_cmds(input string tag);
    check({tag, "_ncmds"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  // Wait for READY or ERROR with noise on the inputs that must be ignored
  task automatic wait_idle(input int budget, input string tag);
    logic done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ready || error) begin done = 1'b1; break; end
      read_req   = ($urandom_range(0, 3) == 0);
      init_start = ($urandom_range(0, 7) == 0);
    end
    read_req   = 1'b0;
    init_start = 1'b0;
    check({tag, "_reached_idle"}, done, 1'b1);
    @(negedge clk);
  endtask

  task automatic run_init(input logic [7:0] r0, input logic [7:0] r8, input logic [7:0] r55,
                          input int busy_n, input logic with_req);
    logic       ok;
    logic [2:0] code;
    r_cmd0 = r0; r_cmd8 = r8; r_cmd55 = r55;
    a41_busy = busy_n; a41_cnt = 0;
    model_init(r0, r8, r55, busy_n, ok, code);
    @(negedge clk);
    obs_q.delete();
    init_start = 1'b1;
    read_req   = with_req;
    read_addr  = $urandom;
    @(negedge clk);
    init_start = 1'b0;
    read_req   = 1'b0;
    check("init_restart", {busy, cs_n, ready, error, err_code}, {1'b1, 1'b1, 1'b0, 1'b0, 3'd0});
    wait_idle(3000, "init");
    compare_cmds("init");
    check("init_ready", ready, ok);
    check("init_error", error, !ok);
    check("init_code", err_code, code);
    check("init_cs_n", cs_n, !ok);
    check("init_rdata", read_data, exp_rd);
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [31:0] data, input int l,
                          input logic [7:0] resp);
    logic ok;
    ok = (resp == 8'h00) && (l <= 1000);
    d17 = data; lat17 = l; r_cmd17 = resp;
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(mk(8'h51, addr, 8'hFF));
    rv_cnt    = 0;
    read_req  = 1'b1;
    read_addr = addr;
    @(negedge clk);
    read_req  = 1'b0;
    read_addr = $urandom;
    wait_idle(l + 50, "read");
    if (ok) exp_rd = data;
    compare_cmds("read");
    check("read_ready", ready, ok);
    check("read_error", error, !ok);
    check("read_code", err_code, ok ? 3'd0 : 3'd5);
    check("read_cs_n", cs_n, !ok);
    check("read_valid_cnt", rv_cnt, ok ? 1 : 0);
    check("read_data", read_data, exp_rd);
    if (ok) begin
      check("read_ready_with_valid", rv_ready, 1'b1);
      check("read_valid_data", rv_data, data);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, {ready, busy, error, err_code, read_data, read_valid, cs_n,
                bus.cmd_start, bus.cmd_number, bus.cmd_args, bus.cmd_crc},
               {1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 8'h00});
  endtask

  initial begin
    logic found;
    reset = 1'b1; init_start = 1'b0; read_req = 1'b0; read_addr = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset_state");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("idle_hold");

    // Nominal init: ACMD41 busy twice then ready; then the reference read
    run_init(8'h01, 8'h01, 8'h01, 2, 1'b0);
    run_read(32'h0000_1200, 32'hDEAD_BEEF, 200, 8'h00);

    // Random re-inits (sometimes with read_req colliding) and reads
    for (int it = 0; it < 4; it++) begin
      run_init(8'h01, 8'h01, 8'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 3; k++)
        run_read($urandom, $urandom, $urandom_range(1, 300), 8'h00);
    end

    // CMD17 latency boundary, then timeout
    run_read($urandom, $urandom, 1000, 8'h00);
    run_read($urandom, $urandom, 1001, 8'h00);

    // Bad CMD17 response
    run_init(8'h01, 8'h01, 8'h00, 0, 1'b0);
    run_read($urandom, $urandom, $urandom_range(1, 50), 8'h04);

    // Bad CMD0, then a clean restart
    run_init(8'hFF, 8'h01, 8'h01, 0, 1'b0);
    run_init(8'h01, 8'h01, 8'h01, 1, 1'b0);

    // Bad CMD8, bad CMD55, ACMD41 exhaustion
    run_init(8'h01, 8'h05, 8'h01, 0, 1'b0);
    run_init(8'h01, 8'h01, 8'h04, 0, 1'b0);
    run_init(8'h01, 8'h01, 8'h01, -1, 1'b0);

    // Reset while CMD8 is in flight
    r_cmd0 = 8'h01; r_cmd8 = 8'h01; r_cmd55 = 8'h01; a41_busy = 0;
    lat8 = 400;
    @(negedge clk);
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.cmd_start && bus.cmd_number == 8'h48) begin found = 1'b1; break; end
    end
    check("cmd8_seen", found, 1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outs("reset_mid_cmd8");
    reset = 1'b0;
    lat8 = 0;
    exp_rd = 32'h0;
    run_init(8'h01, 8'h01, 8'h01, 2, 1'b0);
    run_read(32'h0000_1200, 32'hDEAD_BEEF, 200, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_init_ctrl.md
# sd_init_ctrl

Sequencer that owns the `sd_cmd` command engine and brings an SD card in SPI mode from power-up to ready. It runs the power-up clocks, then CMD0, CMD8 and the CMD55/ACMD41 loop, then serves single-block CMD17 reads on request. It sits between the user logic (init/read requests) and `sd_cmd`, driving its command fields and `start`, and checking the R1 flags `sd_cmd` returns.

## Interface
- `POWERUP_CYCLES`, 80: cycles with `cs_n` high and no command before CMD0.
- `RETRY_MAX`, 255: maximum CMD55/ACMD41 attempts before error.
- `GAP_CYCLES`, 2: cycles `cmd_start` is held low between commands; minimum 1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `init_start`  in  1  begin or restart initialization; sampled in IDLE, READY and ERROR.
- `read_req`  in  1  request one CMD17 read; sampled in READY only.
- `read_addr`  in  32  CMD17 argument; sampled with `read_req`.
- `ready`  out  1  card initialized, accepting `read_req`.
- `busy`  out  1  high in any state except IDLE, READY and ERROR.
- `error`  out  1  sticky failure flag.
- `err_code`  out  3  failure cause: 1 = CMD0, 2 = CMD8, 3 = CMD55, 4 = ACMD41 retries exhausted, 5 = CMD17.
- `read_data`  out  32  last successfully read word.
- `read_valid`  out  1  one-cycle pulse when `read_data` updates.
- `cs_n`  out  1  card chip select.
- `cmd_number`  out  8  to `sd_cmd`; value is 0x40 | index.
- `cmd_args`  out  32  to `sd_cmd`.
- `cmd_crc`  out  8  to `sd_cmd`.
- `cmd_start`  out  1  to `sd_cmd` `start`.
- `cmd_done`  in  1  from `sd_cmd` `done`.
- `cmd_resp`  in  8  from `sd_cmd` `response_flags`.
- `cmd_data`  in  32  from `sd_cmd` `data_transmission`.

## Operation
- States and commands:
  - IDLE, POWERUP, ERROR and READY issue no command.
  - SEND_CMD0 issues 0x40 / 0x00000000 / 0x95.
  - SEND_CMD8 issues 0x48 / 0x000001AA / 0x87.
  - SEND_CMD55 issues 0x77 / 0 / 0x65.
  - SEND_ACMD41 issues 0x69 / 0x40000000 / 0x77.
  - SEND_CMD17 issues 0x51 / `read_addr` / 0xFF.
  - GAP is a wait state between commands.
- Transitions:
  - IDLE goes to POWERUP on `init_start`.
  - POWERUP goes to SEND_CMD0 after `POWERUP_CYCLES`.
  - Each SEND_x completes on `cmd_done`, then the response is checked:
  - CMD0 requires 0x01, then go to CMD8.
  - CMD8 requires 0x01, then go to CMD55.
  - CMD55 accepts 0x00 or 0x01, then go to ACMD41.
  - ACMD41 response 0x00 goes to READY.
  - ACMD41 response 0x01 increments the retry counter and returns to CMD55. When the counter reaches `RETRY_MAX`, go to ERROR with code 4.
  - CMD17 requires 0x00 and `cmd_done` within 1000 cycles of `cmd_start` rising. On success, latch `cmd_data` into `read_data`, pulse `read_valid` and return to READY.
  - Any other response goes to ERROR with the code for that command.
  - READY goes to SEND_CMD17 on `read_req`.
  - READY or ERROR goes to POWERUP on `init_start`. This clears `error`, `err_code` and `ready`.
- `init_start` and `read_req` are ignored while `busy`. If both are asserted in READY, `init_start` wins.
- `cs_n` is high in IDLE, POWERUP and ERROR, and low in all other states.
- The retry counter is 8 bits and clears on entering CMD0.
- The command-cycle counter is 11 bits and saturates at 2047.

## Timing
- All outputs are registered. Reset values:
  - `cs_n` = 1.
  - All other outputs = 0.
  - State = IDLE.
- `reset` takes effect in the cycle it is sampled, including mid-command: `cmd_start` is low the next cycle.
- Command handshake:
  - `cmd_number`, `cmd_args` and `cmd_crc` become valid in the same cycle `cmd_start` rises, and stay stable while `cmd_start` is high.
  - `cmd_start` stays high until `cmd_done` is sampled high.
  - `cmd_resp` and `cmd_data` are sampled in that same cycle.
  - `cmd_start` is low the next cycle and stays low for `GAP_CYCLES` before the next command. This resets `sd_cmd`'s counters.
- The CMD17 timeout is measured with the command-cycle counter: cycle 0 is the first cycle `cmd_start` is high. Done at cycle index ≥ 1001 is a timeout (this matches `sd_cmd`'s internal count > 1000).
- `read_valid` asserts in the cycle after `cmd_done` and lasts exactly one cycle. `ready` reasserts in that same cycle.
- `ready` asserts in the cycle after ACMD41 `cmd_done` with response 0x00.
- `error` asserts in the cycle after the failing `cmd_done`.

## Test plan
- Nominal init: the card model answers CMD0 = 0x01, CMD8 = 0x01, CMD55 = 0x01, ACMD41 = 0x01 twice and then 0x00. Expect:
  - `ready` high.
  - Exactly 3 ACMD41 commands with the listed fields.
  - `cs_n` high for exactly 80 cycles before CMD0.
- Read: in READY, pulse `read_req` with `read_addr` = 0x00001200; model returns R1 0x00 and `cmd_data` = 0xDEADBEEF at cycle 200. Expect:
  - `cmd_args` = 0x00001200.
  - One `read_valid` pulse with `read_data` = 0xDEADBEEF.
  - `ready` high again in the same cycle as `read_valid`.
- CMD17 timeout: `cmd_done` arrives at cycle index 1001 with response 0x00. Expect `error` = 1, `err_code` = 5, no `read_valid`, `cs_n` = 1.
- Bad CMD0: response 0xFF. Expect `err_code` = 1. A following `init_start` restarts POWERUP with `error` cleared.
- ACMD41 exhaustion with `RETRY_MAX` = 3 and ACMD41 always 0x01. Expect exactly 3 ACMD41 commands, then `err_code` = 4.
- Reset mid-CMD8: assert `reset` while `cmd_start` is high. Expect all outputs at their reset values the next cycle, and `init_start` then produces the nominal sequence.
